qsn_deshift_controller_len17: RTL and testbench
===============================================

Name: qsn_deshift_controller_len17

Overview:
- Inverse-permutation controller for the 17-lane QSN barrel shifter.
- On the forward path, each accepted shift factor is recorded in a FIFO.
- When the shifted messages return from the check-node stage, the block pops the matching factor and issues registered left/right/merge selects that undo the cyclic shift, restoring the original lane order.
- Sits between the layer scheduler (forward push) and the de-shift QSN instance (return path).

Parameters:
- PERMUTATION_LENGTH, 17: cyclic shift modulus; this block is fixed at 17 (5-bit factors, 16-bit merge select).
- FIFO_DEPTH, 8: number of outstanding forward shift factors; power of two, ≥2.

Ports:
- sys_clk  input  1  system clock, all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- fwd_valid  input  1  forward shift factor present.
- fwd_shift  input  5  forward shift factor, legal range 0..16.
- fwd_ready  output  1  FIFO can accept a factor (= not full).
- ret_valid  input  1  returning message block present; pops one factor. No backpressure.
- out_valid  output  1  de-shift selects valid this cycle.
- left_sel  output  5  de-shift left select.
- right_sel  output  5  de-shift right select.
- merge_sel  output  16  de-shift merge select.
- underflow_err  output  1  sticky: ret_valid seen while FIFO empty.
- overflow_err  output  1  sticky: fwd_valid seen while fwd_ready low.

Behaviour:
- Reset (async, rstn=0): FIFO emptied; read/write pointers = 0; out_valid = 0; left_sel/right_sel/merge_sel = 0; both error flags = 0. Reset mid-operation discards all stored factors.
- Push: fwd_valid & fwd_ready writes fwd_shift at the write pointer, which then increments.
  - fwd_valid & !fwd_ready drops the factor and sets overflow_err.
  - fwd_ready is a pure function of registered occupancy; a pop in the same cycle does not make a full FIFO accept.
- Pop: ret_valid & not empty reads factor s at the read pointer, which then increments.
  - ret_valid & empty sets underflow_err, leaves pointers unchanged, and asserts no out_valid. There is no bypass from a same-cycle push.
- Simultaneous push and pop with the FIFO neither full nor empty: both happen; occupancy unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
- Inverse factor: inv = (s==0) ? 0 : 17−s, computed 5 bits wide.
- Output register, 1-cycle latency from the pop cycle:
  - out_valid = 1.
  - left_sel = inv.
  - right_sel = (inv≠0) ? 17−inv : 0 (equals s).
  - merge_sel = (inv≠0) ? (16'hFFFF >> (inv−1)) : 16'h0000.
- In a cycle with no pop: out_valid = 0 and the select outputs hold their last values.
- Stored values 17..31 are illegal: inv is forced to 0, and all selects for that pop are 0.
- Error flags clear only on reset.

Optional Feature:
- Macro: QSN_DESHIFT_OCCUPANCY_EN.
- Defined: adds output port occupancy [$clog2(FIFO_DEPTH):0], the registered count of stored factors (0..FIFO_DEPTH). It is 0 after reset and updates the cycle after each push/pop.
- Undefined: port absent, no counter logic; FIFO behaviour identical.

Test Plan:
- Push s=5, then ret_valid -> next cycle out_valid=1, left_sel=12, right_sel=5, merge_sel=16'b0000000000011111.
- Push 0, 1, 16; pop three times back to back -> selects (0,0,16'h0000), (16,1,16'h0001), (1,16,16'hFFFF) on three consecutive cycles, in FIFO order.
- Push 8 factors (FIFO_DEPTH=8) -> fwd_ready=0. Push a 9th -> overflow_err=1 and the 9th factor is absent from the pop sequence.
- ret_valid on an empty FIFO in the same cycle as a push of s=3 -> underflow_err=1, out_valid=0. The next pop returns left_sel=14, right_sel=3, merge_sel=16'h0007.
- Push 4 factors, assert rstn=0 for one cycle, then pop -> all outputs 0, underflow_err=1, and no stale factor is emitted.
- With QSN_DESHIFT_OCCUPANCY_EN defined: push 3, then simultaneous push+pop, then pop 1 -> occupancy 3, 3, 2.

Source files
------------

// File: rtl/qsn_deshift_controller_len17.sv
// Inverse-permutation controller for the 17-lane QSN de-shift path: FIFO of forward shift factors,
// popped on return to drive registered left/right/merge selects. Optional macro: QSN_DESHIFT_OCCUPANCY_EN.
module qsn_deshift_controller_len17 #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        sys_clk,
  input  logic        rstn,
  input  logic        fwd_valid,
  input  logic [4:0]  fwd_shift,
  output logic        fwd_ready,
  input  logic        ret_valid,
  output logic        out_valid,
  output logic [4:0]  left_sel,
  output logic [4:0]  right_sel,
  output logic [15:0] merge_sel,
  output logic        underflow_err,
  output logic        overflow_err
`ifdef QSN_DESHIFT_OCCUPANCY_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0] occupancy
`endif
);

  localparam int unsigned PERMUTATION_LENGTH = 17;
  localparam int unsigned PTR_W              = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  PERM               = 5'(PERMUTATION_LENGTH);
  localparam logic [4:0]  MAX_SHIFT          = 5'(PERMUTATION_LENGTH - 1);

  logic [4:0]     mem_q [FIFO_DEPTH];
  logic [4:0]     mem_d [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] count_d;
  logic           full_q, full_d;
  logic           out_valid_q, out_valid_d;
  logic [4:0]     left_sel_q, left_sel_d;
  logic [4:0]     right_sel_q, right_sel_d;
  logic [15:0]    merge_sel_q, merge_sel_d;
  logic           underflow_q, underflow_d;
  logic           overflow_q, overflow_d;

  logic           empty;
  logic           push;
  logic           pop;
  logic [4:0]     rd_data;
  logic [4:0]     inv;

  // FIFO control, inverse factor and next-state select computation
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = 1'b0;
    left_sel_d  = left_sel_q;
    right_sel_d = right_sel_q;
    merge_sel_d = merge_sel_q;
    inv         = 5'd0;

    empty   = (wr_ptr_q == rd_ptr_q);
    push    = fwd_valid & ~full_q;
    pop     = ret_valid & ~empty;
    rd_data = mem_q[rd_ptr_q[PTR_W-1:0]];

    underflow_d = underflow_q | (ret_valid & empty);
    overflow_d  = overflow_q | (fwd_valid & full_q);

    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = fwd_shift;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end

    // Illegal stored factors (17..31) collapse to the identity permutation
    if (rd_data != 5'd0 && rd_data <= MAX_SHIFT) begin
      inv = PERM - rd_data;
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + (PTR_W+1)'(1);
      out_valid_d = 1'b1;
      left_sel_d  = inv;
      right_sel_d = (inv != 5'd0) ? PERM - inv : 5'd0;
      merge_sel_d = (inv != 5'd0) ? (16'hFFFF >> (inv - 5'd1)) : 16'h0000;
    end

    count_d = wr_ptr_d - rd_ptr_d;
    full_d  = (count_d == (PTR_W+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 5'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
      left_sel_q  <= 5'd0;
      right_sel_q <= 5'd0;
      merge_sel_q <= 16'h0000;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      left_sel_q  <= left_sel_d;
      right_sel_q <= right_sel_d;
      merge_sel_q <= merge_sel_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef QSN_DESHIFT_OCCUPANCY_EN
  logic [PTR_W:0] occupancy_q;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) occupancy_q <= '0;
    else       occupancy_q <= count_d;
  end

  assign occupancy = occupancy_q;
`endif

  assign fwd_ready     = ~full_q;
  assign out_valid     = out_valid_q;
  assign left_sel      = left_sel_q;
  assign right_sel     = right_sel_q;
  assign merge_sel     = merge_sel_q;
  assign underflow_err = underflow_q;
  assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_qsn_deshift_controller_len17.sv
// Scoreboard bench for qsn_deshift_controller_len17: directed pushes/pops, expected select triples queued.
module tb_qsn_deshift_controller_len17;

  logic        sys_clk = 1'b0;
  logic        rstn;
  logic        fwd_valid;
  logic [4:0]  fwd_shift;
  logic        fwd_ready;
  logic        ret_valid;
  logic        out_valid;
  logic [4:0]  left_sel;
  logic [4:0]  right_sel;
  logic [15:0] merge_sel;
  logic        underflow_err;
  logic        overflow_err;
`ifdef QSN_DESHIFT_OCCUPANCY_EN
  logic [3:0]  occupancy;
`endif

  int checks   = 0;
  int failures = 0;
  logic [25:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  qsn_deshift_controller_len17 dut (
    .sys_clk       (sys_clk),
    .rstn          (rstn),
    .fwd_valid     (fwd_valid),
    .fwd_shift     (fwd_shift),
    .fwd_ready     (fwd_ready),
    .ret_valid     (ret_valid),
    .out_valid     (out_valid),
    .left_sel      (left_sel),
    .right_sel     (right_sel),
    .merge_sel     (merge_sel),
    .underflow_err (underflow_err),
    .overflow_err  (overflow_err)
`ifdef QSN_DESHIFT_OCCUPANCY_EN
    ,
    .occupancy     (occupancy)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock of stimulus; inputs return to idle just after the edge
  task automatic drive(input logic v, input logic [4:0] s, input logic r);
    fwd_valid = v;
    fwd_shift = s;
    ret_valid = r;
    @(posedge sys_clk);
    #1;
    fwd_valid = 1'b0;
    ret_valid = 1'b0;
  endtask

  task automatic expect_sel(input logic [4:0] l, input logic [4:0] rr, input logic [15:0] m);
    exp_q.push_back({l, rr, m});
  endtask

  // Monitor: every out_valid must match the oldest queued expectation
  always @(negedge sys_clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {6'd0, left_sel, right_sel, merge_sel}, 32'hFFFF_FFFF);
      end else begin
        chk("selects", {6'd0, left_sel, right_sel, merge_sel}, {6'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    fwd_valid = 1'b0;
    fwd_shift = 5'd0;
    ret_valid = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_selects", {6'd0, left_sel, right_sel, merge_sel}, 32'd0);
    chk("rst_fwd_ready", 32'(fwd_ready), 32'd1);
    chk("rst_errs", {30'd0, underflow_err, overflow_err}, 32'd0);
    rstn = 1'b1;
    @(posedge sys_clk);
    #1;

    // Single factor 5
    drive(1'b1, 5'd5, 1'b0);
    expect_sel(5'd12, 5'd5, 16'h001F);
    drive(1'b0, 5'd0, 1'b1);
    chk("pop_out_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 5'd0, 1'b0);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("hold_left_sel", 32'(left_sel), 32'd12);
    chk("hold_merge_sel", 32'(merge_sel), 32'h001F);

    // Boundary factors 0, 1, 16 popped back to back
    drive(1'b1, 5'd0, 1'b0);
    drive(1'b1, 5'd1, 1'b0);
    drive(1'b1, 5'd16, 1'b0);
    expect_sel(5'd0, 5'd0, 16'h0000);
    expect_sel(5'd16, 5'd1, 16'h0001);
    expect_sel(5'd1, 5'd16, 16'hFFFF);
    drive(1'b0, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 1'b0);

    // Fill to depth, overflow with a ninth factor that must never appear
    for (int i = 2; i <= 9; i++) drive(1'b1, 5'(i), 1'b0);
    chk("full_fwd_ready", 32'(fwd_ready), 32'd0);
    chk("no_overflow_yet", 32'(overflow_err), 32'd0);
    drive(1'b1, 5'd10, 1'b0);
    chk("overflow_err", 32'(overflow_err), 32'd1);
    // Pop while full plus push: push still rejected
    expect_sel(5'd15, 5'd2, 16'h0003);
    drive(1'b1, 5'd11, 1'b1);
    chk("pop_frees_slot", 32'(fwd_ready), 32'd1);
    expect_sel(5'd14, 5'd3, 16'h0007);
    expect_sel(5'd13, 5'd4, 16'h000F);
    expect_sel(5'd12, 5'd5, 16'h001F);
    expect_sel(5'd11, 5'd6, 16'h003F);
    expect_sel(5'd10, 5'd7, 16'h007F);
    expect_sel(5'd9,  5'd8, 16'h00FF);
    expect_sel(5'd8,  5'd9, 16'h01FF);
    for (int i = 0; i < 7; i++) drive(1'b0, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 1'b0);
    chk("drained_queue", 32'(exp_q.size()), 32'd0);

    // Underflow with same-cycle push: no bypass
    drive(1'b1, 5'd3, 1'b1);
    chk("underflow_err", 32'(underflow_err), 32'd1);
    chk("underflow_no_valid", 32'(out_valid), 32'd0);
    expect_sel(5'd14, 5'd3, 16'h0007);
    drive(1'b0, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 1'b0);

    // Illegal stored factor collapses to all-zero selects
    drive(1'b1, 5'd20, 1'b0);
    expect_sel(5'd0, 5'd0, 16'h0000);
    drive(1'b0, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 1'b0);

    // Mid-operation reset discards stored factors
    drive(1'b1, 5'd7, 1'b0);
    drive(1'b1, 5'd8, 1'b0);
    drive(1'b1, 5'd9, 1'b0);
    drive(1'b1, 5'd11, 1'b0);
    rstn = 1'b0;
    #1;
    chk("midrst_errs", {30'd0, underflow_err, overflow_err}, 32'd0);
    chk("midrst_fwd_ready", 32'(fwd_ready), 32'd1);
    @(posedge sys_clk);
    #1;
    rstn = 1'b1;
    drive(1'b0, 5'd0, 1'b1);
    chk("postrst_underflow", 32'(underflow_err), 32'd1);
    chk("postrst_out_valid", 32'(out_valid), 32'd0);
    chk("postrst_selects", {6'd0, left_sel, right_sel, merge_sel}, 32'd0);
    drive(1'b0, 5'd0, 1'b0);

    // Occupancy sequence: push 3, push+pop, pop
    drive(1'b1, 5'd1, 1'b0);
    drive(1'b1, 5'd2, 1'b0);
    drive(1'b1, 5'd3, 1'b0);
`ifdef QSN_DESHIFT_OCCUPANCY_EN
    chk("occupancy_3", 32'(occupancy), 32'd3);
`endif
    expect_sel(5'd16, 5'd1, 16'h0001);
    drive(1'b1, 5'd4, 1'b1);
`ifdef QSN_DESHIFT_OCCUPANCY_EN
    chk("occupancy_pushpop", 32'(occupancy), 32'd3);
`endif
    expect_sel(5'd15, 5'd2, 16'h0003);
    drive(1'b0, 5'd0, 1'b1);
`ifdef QSN_DESHIFT_OCCUPANCY_EN
    chk("occupancy_2", 32'(occupancy), 32'd2);
`endif
    expect_sel(5'd14, 5'd3, 16'h0007);
    expect_sel(5'd13, 5'd4, 16'h000F);
    drive(1'b0, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 1'b0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
